// File: rtl/decode_sequencer_pkg.sv
// Shared decode constants and sequencer state encoding for decode_sequencer.
package decode_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE      = 2'd0,
        SEQ_MDU_BUSY  = 2'd1,
        SEQ_SYS_DRAIN = 2'd2,
        SEQ_SYS_FIRE  = 2'd3
    } seq_state_t;

    // MIPS-I opcode / SPECIAL funct encodings
    localparam logic [5:0] SPECIAL = 6'h00;
    localparam logic [5:0] SYSCALL = 6'h0C;
    localparam logic [5:0] MFHI    = 6'h10;
    localparam logic [5:0] MFLO    = 6'h12;
    localparam logic [5:0] MULT    = 6'h18;
    localparam logic [5:0] MULTU   = 6'h19;
    localparam logic [5:0] DIV     = 6'h1A;
    localparam logic [5:0] DIVU    = 6'h1B;

    // True when the decode slot holds SPECIAL with the given funct
    function automatic logic is_special_fn(input logic [5:0] op,
                                           input logic [5:0] fn,
                                           input logic [5:0] want);
        return (op == SPECIAL) && (fn == want);
    endfunction

endpackage

// File: rtl/decode_sequencer_countdown.sv
// Loadable down-counter with zero flag; holds at zero rather than wrapping.
module seq_countdown #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority over decrement; saturate at zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/decode_sequencer.sv
// Decode-stage sequencer: tracks the MDU busy window (stalling HI/LO readers
// and further MDU ops) and drains the pipeline before firing SYSCALL.
// Optional macro MDU_MULT_EN: MULT/MULTU/DIVU also occupy the MDU.
module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter int DIV_CYCLES   = 32,
    parameter int MULT_CYCLES  = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       valid_d,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       stall_in,
    input  logic       flush_d,
    output logic       stall_d,
    output logic       div_start,
    output logic       mdu_busy,
    output logic       hilo_ready,
    output logic       syscall_fire
);

    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULT_LOAD  = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES == 0) ? '0 : CNT_W'(DRAIN_CYCLES - 1);

    seq_state_t       state, next_state;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    logic dec_div, dec_sys, dec_hilo, dec_divu, dec_mult;
    logic dec_start, dec_mdu_op, issue_ok;

    assign dec_div  = is_special_fn(opcode, funct, DIV);
    assign dec_sys  = is_special_fn(opcode, funct, SYSCALL);
    assign dec_hilo = is_special_fn(opcode, funct, MFHI) |
                      is_special_fn(opcode, funct, MFLO);
`ifdef MDU_MULT_EN
    assign dec_divu = is_special_fn(opcode, funct, DIVU);
    assign dec_mult = is_special_fn(opcode, funct, MULT) |
                      is_special_fn(opcode, funct, MULTU);
`else
    assign dec_divu = 1'b0;
    assign dec_mult = 1'b0;
`endif
    assign dec_start  = dec_div | dec_divu;
    assign dec_mdu_op = dec_start | dec_mult;

    // stall_d is always 0 in IDLE, so it is left out here to keep stall_d
    // free of any path back from issue.
    assign issue_ok = valid_d & ~stall_in & ~flush_d;

    seq_countdown #(.CNT_W(CNT_W)) u_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= SEQ_IDLE;
        else
            state <= next_state;
    end

    // hilo_ready pulses the cycle after the last busy cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            hilo_ready <= 1'b0;
        else
            hilo_ready <= (state == SEQ_MDU_BUSY) && cnt_zero;
    end

    assign mdu_busy     = (state == SEQ_MDU_BUSY);
    assign syscall_fire = (state == SEQ_SYS_FIRE);

    // Next-state, counter control and decode stall
    always_comb begin
        next_state   = state;
        stall_d      = 1'b0;
        div_start    = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = dec_mult ? MULT_LOAD : DIV_LOAD;
        case (state)
            SEQ_IDLE: begin
                if (issue_ok && dec_mdu_op) begin
                    div_start  = dec_start;
                    cnt_load   = 1'b1;
                    next_state = SEQ_MDU_BUSY;
                end else if (issue_ok && dec_sys) begin
                    if (DRAIN_CYCLES == 0) begin
                        next_state = SEQ_SYS_FIRE;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_load_val = DRAIN_LOAD;
                        next_state   = SEQ_SYS_DRAIN;
                    end
                end
            end
            SEQ_MDU_BUSY: begin
                stall_d = valid_d & (dec_hilo | dec_mdu_op | dec_sys);
                cnt_dec = 1'b1;
                if (cnt_zero)
                    next_state = SEQ_IDLE;
            end
            SEQ_SYS_DRAIN: begin
                stall_d = valid_d;
                cnt_dec = 1'b1;
                if (cnt_zero)
                    next_state = SEQ_SYS_FIRE;
            end
            SEQ_SYS_FIRE: begin
                stall_d    = valid_d;
                next_state = SEQ_IDLE;
            end
            default: next_state = SEQ_IDLE;
        endcase
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: main instance uses default latencies,
// a second instance has DRAIN_CYCLES=0 for the immediate-fire case.
module tb_decode_sequencer;

    localparam logic [5:0] OP_SP   = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] F_SYS   = 6'h0C;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_DIV   = 6'h1A;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       valid_d, stall_in, flush_d;
    logic [5:0] opcode, funct;
    logic       a_stall_d, a_div_start, a_mdu_busy, a_hilo_ready, a_syscall_fire;
    logic       b_stall_d, b_div_start, b_mdu_busy, b_hilo_ready, b_syscall_fire;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    decode_sequencer dut_a (
        .clock(clock), .reset_n(reset_n), .valid_d(valid_d), .opcode(opcode),
        .funct(funct), .stall_in(stall_in), .flush_d(flush_d),
        .stall_d(a_stall_d), .div_start(a_div_start), .mdu_busy(a_mdu_busy),
        .hilo_ready(a_hilo_ready), .syscall_fire(a_syscall_fire)
    );

    decode_sequencer #(.DRAIN_CYCLES(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .valid_d(valid_d), .opcode(opcode),
        .funct(funct), .stall_in(stall_in), .flush_d(flush_d),
        .stall_d(b_stall_d), .div_start(b_div_start), .mdu_busy(b_mdu_busy),
        .hilo_ready(b_hilo_ready), .syscall_fire(b_syscall_fire)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic instr(input logic v, input logic [5:0] op, input logic [5:0] fn);
        valid_d = v;
        opcode  = op;
        funct   = fn;
    endtask

    initial begin
        reset_n = 1'b0; stall_in = 1'b0; flush_d = 1'b0;
        instr(1'b0, OP_SP, 6'h00);
        repeat (2) @(posedge clock);
        mid();
        chk("rst_mdu_busy", a_mdu_busy, 1'b0);
        chk("rst_hilo_ready", a_hilo_ready, 1'b0);
        chk("rst_syscall_fire", a_syscall_fire, 1'b0);
        chk("rst_stall_d", a_stall_d, 1'b0);
        reset_n = 1'b1;

        // DIV then MFHI held in decode
        next_cycle(); instr(1'b1, OP_SP, F_DIV); mid();
        chk("div_start_t", a_div_start, 1'b1);
        chk("div_stall_t", a_stall_d, 1'b0);
        chk("div_busy_t", a_mdu_busy, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            next_cycle(); instr(1'b1, OP_SP, F_MFHI); mid();
            chk("mfhi_busy", a_mdu_busy, 1'b1);
            chk("mfhi_stall", a_stall_d, 1'b1);
            chk("mfhi_hilo_early", a_hilo_ready, 1'b0);
            chk("mfhi_no_div_start", a_div_start, 1'b0);
        end
        next_cycle(); mid();
        chk("t33_busy", a_mdu_busy, 1'b0);
        chk("t33_hilo", a_hilo_ready, 1'b1);
        chk("t33_mfhi_issue", a_stall_d, 1'b0);
        next_cycle(); instr(1'b1, OP_ADDIU, 6'h00); mid();
        chk("t34_hilo_pulse_end", a_hilo_ready, 1'b0);

        // DIV, independent ADDIU, then SYSCALL waiting behind the MDU
        next_cycle(); instr(1'b1, OP_SP, F_DIV); mid();
        chk("div2_start", a_div_start, 1'b1);
        next_cycle(); instr(1'b1, OP_ADDIU, 6'h00); mid();
        chk("addiu_no_stall", a_stall_d, 1'b0);
        chk("addiu_busy", a_mdu_busy, 1'b1);
        for (int k = 2; k <= 32; k++) begin
            next_cycle(); instr(1'b1, OP_SP, F_SYS); mid();
            chk("sys_busy_stall", a_stall_d, 1'b1);
            chk("sys_busy_no_fire", a_syscall_fire, 1'b0);
            chk("sys_busy_no_hilo", a_hilo_ready, 1'b0);
        end
        next_cycle(); mid();
        chk("sys_t33_hilo", a_hilo_ready, 1'b1);
        chk("sys_t33_issue", a_stall_d, 1'b0);
        chk("sys_t33_no_fire", a_syscall_fire, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle(); instr(1'b1, OP_ADDIU, 6'h00); mid();
            chk("drain_stall", a_stall_d, 1'b1);
            chk("drain_fire", a_syscall_fire, (k == 4));
        end
        next_cycle(); mid();
        chk("post_fire_clear", a_syscall_fire, 1'b0);
        chk("post_fire_idle", a_stall_d, 1'b0);

        // stall_in blocks DIV issue
        next_cycle(); instr(1'b1, OP_SP, F_DIV); stall_in = 1'b1; mid();
        chk("stall_in_no_start", a_div_start, 1'b0);
        chk("stall_in_no_stall_d", a_stall_d, 1'b0);
        next_cycle(); stall_in = 1'b0; instr(1'b0, OP_SP, 6'h00); mid();
        chk("stall_in_idle", a_mdu_busy, 1'b0);

        // flush_d blocks DIV issue
        next_cycle(); instr(1'b1, OP_SP, F_DIV); flush_d = 1'b1; mid();
        chk("flush_no_start", a_div_start, 1'b0);
        next_cycle(); flush_d = 1'b0; instr(1'b0, OP_SP, 6'h00); mid();
        chk("flush_idle", a_mdu_busy, 1'b0);

        // Unrecognised encoding never stalls
        next_cycle(); instr(1'b1, 6'h3F, 6'h3F); mid();
        chk("unknown_no_stall", a_stall_d, 1'b0);

        // MULT: MDU op only with the optional feature
        next_cycle(); instr(1'b1, OP_SP, F_MULT); mid();
        chk("mult_no_div_start", a_div_start, 1'b0);
`ifdef MDU_MULT_EN
        for (int k = 1; k <= 4; k++) begin
            next_cycle(); instr(1'b0, OP_SP, 6'h00); mid();
            chk("mult_busy", a_mdu_busy, 1'b1);
        end
        next_cycle(); mid();
        chk("mult_done", a_mdu_busy, 1'b0);
        chk("mult_hilo", a_hilo_ready, 1'b1);
`else
        next_cycle(); instr(1'b0, OP_SP, 6'h00); mid();
        chk("mult_ordinary", a_mdu_busy, 1'b0);
`endif

        // Reset in the middle of a DIV window, off the clock edge
        next_cycle(); instr(1'b1, OP_SP, F_DIV); mid();
        chk("rstdiv_start", a_div_start, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            next_cycle(); instr(1'b0, OP_SP, 6'h00);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_busy", a_mdu_busy, 1'b0);
        chk("async_rst_hilo", a_hilo_ready, 1'b0);
        #3 reset_n = 1'b1;
        next_cycle(); instr(1'b1, OP_SP, F_MFHI); mid();
        chk("post_rst_mfhi", a_stall_d, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            next_cycle(); instr(1'b0, OP_SP, 6'h00); mid();
            chk("post_rst_no_hilo", a_hilo_ready, 1'b0);
        end

        // DRAIN_CYCLES=0: fire on the very next cycle
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        next_cycle(); instr(1'b1, OP_SP, F_SYS); mid();
        chk("d0_issue", b_stall_d, 1'b0);
        next_cycle(); instr(1'b1, OP_ADDIU, 6'h00); mid();
        chk("d0_fire", b_syscall_fire, 1'b1);
        chk("d0_fire_stall", b_stall_d, 1'b1);
        chk("d3_not_yet", a_syscall_fire, 1'b0);
        next_cycle(); mid();
        chk("d0_fire_end", b_syscall_fire, 1'b0);
        chk("d0_idle", b_stall_d, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
